// File: rtl/tower_seed_sorter_if.sv
// Tower-in / seed-out stream bundle plus per-event status for the seed sorter.
// The master drives towers and out_ready; the slave (the sorter) drives the rest.
interface tower_seed_sorter_if #(
  parameter int W  = 10,
  parameter int CW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [W-1:0]  in_eta;
  logic [W-1:0]  in_phi;
  logic [W-1:0]  in_et;
  logic [W-1:0]  in_e;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [W-1:0]  out_eta;
  logic [W-1:0]  out_phi;
  logic [W-1:0]  out_et;
  logic [W-1:0]  out_e;
  logic [CW-1:0] num_seeds;
  logic          overflow;
  logic          phi_err;
  logic          frame_done;

  modport master (
    output in_valid, in_last, in_eta, in_phi, in_et, in_e, out_ready,
    input  in_ready, out_valid, out_last, out_eta, out_phi, out_et, out_e,
    input  num_seeds, overflow, phi_err, frame_done
  );

  modport slave (
    input  in_valid, in_last, in_eta, in_phi, in_et, in_e, out_ready,
    output in_ready, out_valid, out_last, out_eta, out_phi, out_et, out_e,
    output num_seeds, overflow, phi_err, frame_done
  );
endinterface

// File: rtl/tower_seed_sorter.sv
// Collects one event's towers into a descending-Et seed list (insertion sort, one tower
// per cycle), then streams the list out hardest-first for the jet selector.
//
// state     | meaning
// S_COLLECT | accepting towers, inserting survivors into the sorted list
// S_DRAIN   | streaming the list out; no towers accepted
module tower_seed_sorter #(
  parameter int W         = 10,
  parameter int MAX_SEEDS = 16,
  parameter int ET_THRESH = 5,
  parameter int PHI_MAX   = 61,
  parameter int CW        = $clog2(MAX_SEEDS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  tower_seed_sorter_if.slave  bus
);

  localparam int            IW      = $clog2(MAX_SEEDS);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SEEDS);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  eta_q [MAX_SEEDS];
  logic [W-1:0]  phi_q [MAX_SEEDS];
  logic [W-1:0]  et_q  [MAX_SEEDS];
  logic [W-1:0]  e_q   [MAX_SEEDS];
  logic [W-1:0]  eta_d [MAX_SEEDS];
  logic [W-1:0]  phi_d [MAX_SEEDS];
  logic [W-1:0]  et_d  [MAX_SEEDS];
  logic [W-1:0]  e_d   [MAX_SEEDS];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic          perr_q, perr_d;
  logic          fdone_q, fdone_d;

  logic [MAX_SEEDS-1:0] ge;
  logic [IW-1:0]        rd_idx;
  logic                 accept, phi_bad, et_ok, ins, full;
  logic                 out_valid, at_last, fire;

  // ge[i]: entry i stays ahead of the incoming tower (equal Et keeps arrival order)
  always_comb begin
    ge = '0;
    for (int i = 0; i < MAX_SEEDS; i++) begin
      ge[i] = (CW'(i) < cnt_q) && (et_q[i] >= bus.in_et);
    end
  end

  assign accept    = bus.in_valid && (state_q == S_COLLECT);
  assign phi_bad   = bus.in_phi > W'(PHI_MAX);
  assign et_ok     = bus.in_et >= W'(ET_THRESH);
  assign ins       = accept && !phi_bad && et_ok;
  assign full      = (cnt_q == MAX_CNT);

  assign rd_idx    = rd_q[IW-1:0];
  assign out_valid = (state_q == S_DRAIN) && (cnt_q != '0);
  assign at_last   = out_valid && (rd_q == cnt_q - CW'(1));
  assign fire      = out_valid && bus.out_ready;

  assign bus.in_ready   = (state_q == S_COLLECT);
  assign bus.out_valid  = out_valid;
  assign bus.out_last   = at_last;
  assign bus.out_eta    = out_valid ? eta_q[rd_idx] : '0;
  assign bus.out_phi    = out_valid ? phi_q[rd_idx] : '0;
  assign bus.out_et     = out_valid ? et_q[rd_idx]  : '0;
  assign bus.out_e      = out_valid ? e_q[rd_idx]   : '0;
  assign bus.num_seeds  = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.phi_err    = perr_q;
  // An empty event finishes in its first drain cycle; a full one the cycle after out_last.
  assign bus.frame_done = fdone_q || ((state_q == S_DRAIN) && (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    perr_d  = perr_q;
    fdone_d = 1'b0;
    eta_d   = eta_q;
    phi_d   = phi_q;
    et_d    = et_q;
    e_d     = e_q;

    case (state_q)
      S_COLLECT: begin
        if (accept) begin
          if (phi_bad) perr_d = 1'b1;
          if (ins) begin
            // Entries behind the insertion point shift down; the tail falls off when full.
            if (!ge[0]) begin
              eta_d[0] = bus.in_eta;
              phi_d[0] = bus.in_phi;
              et_d[0]  = bus.in_et;
              e_d[0]   = bus.in_e;
            end
            for (int i = 1; i < MAX_SEEDS; i++) begin
              if (!ge[i]) begin
                if (ge[i-1]) begin
                  eta_d[i] = bus.in_eta;
                  phi_d[i] = bus.in_phi;
                  et_d[i]  = bus.in_et;
                  e_d[i]   = bus.in_e;
                end else begin
                  eta_d[i] = eta_q[i-1];
                  phi_d[i] = phi_q[i-1];
                  et_d[i]  = et_q[i-1];
                  e_d[i]   = e_q[i-1];
                end
              end
            end
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CW'(1);
          end
          if (bus.in_last) begin
            state_d = S_DRAIN;
            rd_d    = '0;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_COLLECT;
          ovf_d   = 1'b0;
          perr_d  = 1'b0;
        end else if (fire) begin
          if (at_last) begin
            state_d = S_COLLECT;
            cnt_d   = '0;
            rd_d    = '0;
            ovf_d   = 1'b0;
            perr_d  = 1'b0;
            fdone_d = 1'b1;
          end else begin
            rd_d = rd_q + CW'(1);
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      fdone_q <= 1'b0;
      for (int i = 0; i < MAX_SEEDS; i++) begin
        eta_q[i] <= '0;
        phi_q[i] <= '0;
        et_q[i]  <= '0;
        e_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
      fdone_q <= fdone_d;
      eta_q   <= eta_d;
      phi_q   <= phi_d;
      et_q    <= et_d;
      e_q     <= e_d;
    end
  end

endmodule

// File: tb/tb_tower_seed_sorter.sv
// Scoreboard bench for tower_seed_sorter: the stimulus side queues expected seed beats,
// a negedge monitor pops and compares every output handshake.
module tb_tower_seed_sorter;
  localparam int W    = 10;
  localparam int MAXS = 16;
  localparam int CW   = 5;
  localparam int THR  = 5;
  localparam int PHIM = 61;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tower_seed_sorter_if #(.W(W), .CW(CW)) bus ();

  tower_seed_sorter #(
    .W(W), .MAX_SEEDS(MAXS), .ET_THRESH(THR), .PHI_MAX(PHIM), .CW(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] eta;
    logic [W-1:0] phi;
    logic [W-1:0] et;
    logic [W-1:0] e;
    logic         last;
  } beat_t;

  beat_t        sb [$];
  int           total = 0;
  int           bad = 0;
  int           beats_seen = 0;
  logic [W-1:0] ev_eta [$];
  logic [W-1:0] ev_phi [$];
  logic [W-1:0] ev_et  [$];
  logic [W-1:0] ev_e   [$];
  logic [CW-1:0] last_num;
  logic          last_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: a beat is taken when out_valid && out_ready are seen at negedge.
  beat_t held;
  beat_t got;
  beat_t exp_b;
  logic  stalled = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else if (bus.out_valid) begin
      got = '{eta: bus.out_eta, phi: bus.out_phi, et: bus.out_et, e: bus.out_e,
              last: bus.out_last};
      chk("in_ready_during_drain", {63'd0, bus.in_ready}, 64'd0);
      if (stalled) chk("stall_hold", 64'(got), 64'(held));
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          exp_b = sb.pop_front();
          chk("beat", 64'(got), 64'(exp_b));
        end
        beats_seen++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = got;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic clear_ev();
    ev_eta.delete(); ev_phi.delete(); ev_et.delete(); ev_e.delete();
  endtask

  task automatic add_tw(input int eta, input int phi, input int et, input int e);
    ev_eta.push_back(W'(eta)); ev_phi.push_back(W'(phi));
    ev_et.push_back(W'(et));   ev_e.push_back(W'(e));
  endtask

  // Reference: threshold, stable sort by descending Et, truncate to MAXS.
  task automatic build_expect(output int n, output logic ovf, output logic perr);
    int    idx [$];
    int    p;
    beat_t b;
    perr = 1'b0;
    for (int i = 0; i < ev_et.size(); i++) begin
      if (ev_phi[i] > W'(PHIM)) begin
        perr = 1'b1;
      end else if (ev_et[i] >= W'(THR)) begin
        p = idx.size();
        for (int j = 0; j < idx.size(); j++) begin
          if (ev_et[idx[j]] < ev_et[i]) begin
            p = j;
            break;
          end
        end
        idx.insert(p, i);
      end
    end
    ovf = (idx.size() > MAXS);
    while (idx.size() > MAXS) void'(idx.pop_back());
    n = idx.size();
    for (int j = 0; j < n; j++) begin
      b.eta  = ev_eta[idx[j]];
      b.phi  = ev_phi[idx[j]];
      b.et   = ev_et[idx[j]];
      b.e    = ev_e[idx[j]];
      b.last = (j == n - 1);
      sb.push_back(b);
    end
  endtask

  task automatic send(input logic [W-1:0] eta, input logic [W-1:0] phi,
                      input logic [W-1:0] et, input logic [W-1:0] e, input logic last);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) fail_now("in_ready_timeout");
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.in_eta   = eta;
    bus.in_phi   = phi;
    bus.in_et    = et;
    bus.in_e     = e;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_event(input int mode, output int n);
    logic ovf, perr;
    build_expect(n, ovf, perr);
    bus.out_ready = (mode == 0);
    for (int i = 0; i < ev_et.size(); i++)
      send(ev_eta[i], ev_phi[i], ev_et[i], ev_e[i], i == ev_et.size() - 1);
    last_num = bus.num_seeds;
    last_ovf = bus.overflow;
    chk("num_seeds", 64'(bus.num_seeds), 64'(n));
    chk("overflow", {63'd0, bus.overflow}, {63'd0, ovf});
    chk("phi_err", {63'd0, bus.phi_err}, {63'd0, perr});
    if (n == 0) begin
      chk("empty_frame_done", {63'd0, bus.frame_done}, 64'd1);
      chk("empty_no_valid", {63'd0, bus.out_valid}, 64'd0);
      @(posedge clk); #1;
      chk("empty_frame_done_pulse", {63'd0, bus.frame_done}, 64'd0);
      chk("empty_in_ready_back", {63'd0, bus.in_ready}, 64'd1);
    end
  endtask

  // mode 0: always ready; 1: low 4 cycles then toggling; 2: random stalls
  task automatic drain(input int mode);
    int k = 0;
    bit seen = 0;
    while (k < 3000) begin
      if (bus.frame_done) begin
        seen = 1;
        break;
      end
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (k < 4) ? 1'b0 : ((k % 2) == 0);
        default: bus.out_ready = ($urandom_range(0, 2) != 0);
      endcase
      @(posedge clk); #1;
      k++;
    end
    if (!seen) fail_now("frame_done_timeout");
    chk("fd_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("fd_num_seeds", 64'(bus.num_seeds), 64'd0);
    chk("fd_overflow", {63'd0, bus.overflow}, 64'd0);
    chk("fd_phi_err", {63'd0, bus.phi_err}, 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("frame_done_pulse", {63'd0, bus.frame_done}, 64'd0);
  endtask

  task automatic run_event(input int mode);
    int n;
    send_event(mode, n);
    if (n > 0) drain(mode);
  endtask

  initial begin
    int n;
    int base;
    int k;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    bus.in_eta = '0; bus.in_phi = '0; bus.in_et = '0; bus.in_e = '0;
    rst_n = 1'b0;
    #3;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_num_seeds", 64'(bus.num_seeds), 64'd0);
    chk("rst_flags", {61'd0, bus.overflow, bus.phi_err, bus.frame_done}, 64'd0);
    chk("rst_out_data", {24'd0, bus.out_et, bus.out_eta, bus.out_last, 9'd0}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: threshold, stable tie order, phi at the legal edge
    clear_ev();
    add_tw(1, 10, 3, 101); add_tw(2, 61, 20, 102); add_tw(3, 11, 7, 103);
    add_tw(4, 12, 20, 104); add_tw(5, 0, 12, 105);
    run_event(0);
    chk("t1_num_seeds", 64'(last_num), 64'd4);

    // T2: 20 rising Et towers into a 16-deep list
    clear_ev();
    for (int i = 0; i < 20; i++) add_tw(i, i, 10 + i, 500 + i);
    run_event(0);
    chk("t2_num_seeds", 64'(last_num), 64'd16);
    chk("t2_overflow", {63'd0, last_ovf}, 64'd1);

    // T3: only tower has illegal phi
    clear_ev();
    add_tw(7, 62, 50, 9);
    run_event(0);

    // T4: three seeds under a stall-then-toggle downstream
    clear_ev();
    add_tw(1, 5, 8, 11); add_tw(2, 6, 30, 22); add_tw(3, 7, 15, 33);
    run_event(1);

    // T5: reset after two of five beats, then a fresh two-tower event
    clear_ev();
    add_tw(1, 1, 9, 1); add_tw(2, 2, 40, 2); add_tw(3, 3, 22, 3);
    add_tw(4, 4, 6, 4); add_tw(5, 5, 17, 5);
    base = beats_seen;
    send_event(0, n);
    k = 0;
    while (beats_seen < base + 2 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    if (beats_seen < base + 2) fail_now("t5_beat_timeout");
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("t5_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("t5_num_seeds", 64'(bus.num_seeds), 64'd0);
    chk("t5_no_frame_done", {63'd0, bus.frame_done}, 64'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clear_ev();
    add_tw(8, 20, 5, 77); add_tw(9, 21, 33, 88);
    run_event(0);

    // T6: back-to-back random events with random stalls
    for (int ev = 0; ev < 5; ev++) begin
      int nt;
      clear_ev();
      nt = $urandom_range(1, 24);
      for (int i = 0; i < nt; i++)
        add_tw($urandom_range(0, 1023), $urandom_range(0, 63),
               $urandom_range(0, 40), $urandom_range(0, 1023));
      run_event(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
